// File: rtl/zigzag_pingpong.sv
// Double-buffered 8x8 zigzag/raster coefficient reorder (MODE 0 fwd, 1 inv).
// Define ZIGZAG_RUNLEN_EN to add the out_run zero-run output.
module zigzag_pingpong #(
  parameter int COEF_W = 12,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic [5:0]        out_idx,
  output logic              out_last
`ifdef ZIGZAG_RUNLEN_EN
  ,
  output logic [5:0]        out_run
`endif
);

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [COEF_W-1:0] bank_q [2][64];

  logic [1:0] full_q, full_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;
  logic [5:0] wr_cnt_q, wr_cnt_d;
  logic [5:0] rd_cnt_q, rd_cnt_d;

  logic       wr_fire;
  logic       rd_fire;
  logic [5:0] wr_addr;
  logic [5:0] rd_addr;

  assign in_ready  = !full_q[wr_sel_q];
  assign out_valid = full_q[rd_sel_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Only one side goes through the zigzag table, chosen by MODE.
  assign wr_addr = (MODE == 0) ? wr_cnt_q : ZZ[wr_cnt_q];
  assign rd_addr = (MODE == 0) ? ZZ[rd_cnt_q] : rd_cnt_q;

  assign out_data = bank_q[rd_sel_q][rd_addr];
  assign out_idx  = rd_cnt_q;
  assign out_last = (rd_cnt_q == 6'd63);

  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == 6'd63) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = !wr_sel_q;
      end
    end
    // Write never targets a full bank, so this clear hits the other bit.
    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
      if (out_last) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = !rd_sel_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= 6'd0;
      rd_cnt_q <= 6'd0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank_q[wr_sel_q][wr_addr] <= in_data;
    end
  end

`ifdef ZIGZAG_RUNLEN_EN
  logic [5:0] run_q, run_d;

  always_comb begin
    run_d = run_q;
    if (rd_fire) begin
      if (out_last) begin
        run_d = 6'd0;
      end else if (out_data == '0) begin
        run_d = run_q + 6'd1;
      end else begin
        run_d = 6'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= 6'd0;
    end else begin
      run_q <= run_d;
    end
  end

  assign out_run = run_q;
`endif

endmodule

// File: doc/zigzag_pingpong.md
# zigzag_pingpong

Parametrised, double-buffered 8x8 coefficient reorder stage for the JPEG encode/decode path, sitting between the DCT/quantiser and the entropy coder. It accepts one coefficient per cycle and emits one per cycle, with valid/ready on both sides. `MODE` selects the direction:
- forward: raster in, zigzag out;
- inverse: zigzag in, raster out.

Two 64-entry banks let block N+1 be written while block N is read. This gives a sustained throughput of 1 coefficient/cycle.

## Interface
Parameters:
- `COEF_W`, default 12: coefficient width in bits, signed two's complement; passed through unmodified.
- `MODE`, default 0: 0 = forward (raster in, zigzag out); 1 = inverse (zigzag in, raster out).

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input coefficient valid.
- `in_ready`  out  1  input bank can accept.
- `in_data`  in  COEF_W  input coefficient.
- `out_valid`  out  1  output coefficient valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  COEF_W  output coefficient.
- `out_idx`  out  6  output position within the block, 0..63, in output order.
- `out_last`  out  1  high with `out_idx`==63.
- `out_run`  out  6  only with `ZIGZAG_RUNLEN_EN`; see Configuration.

## Operation
Zigzag table: `zz[k]` is the raster index of the k-th zigzag position, the standard JPEG order:
- 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,
- 56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.

State:
- `bank[2][64]`, COEF_W each;
- `full[1:0]`;
- `wr_sel`, `rd_sel`;
- 6-bit `wr_cnt`, `rd_cnt`.

Write side:
- An input is accepted when `in_valid` && `in_ready`.
- `in_ready` = !`full[wr_sel]`.
- Write address: `wr_cnt` in MODE 0; `zz[wr_cnt]` in MODE 1.
- `wr_cnt` increments on each accept.
- On the accept at `wr_cnt`==63: `wr_cnt` wraps to 0, `full[wr_sel]` is set and `wr_sel` toggles.

Read side:
- `out_valid` = `full[rd_sel]`.
- Read address: `zz[rd_cnt]` in MODE 0; `rd_cnt` in MODE 1.
- `out_data` is combinational from the selected bank entry; `out_idx` = `rd_cnt`.
- A handshake is `out_valid` && `out_ready`; `rd_cnt` increments on each.
- On the handshake at `rd_cnt`==63: `full[rd_sel]` clears, `rd_sel` toggles, `rd_cnt` wraps to 0.

Boundary conditions:
- Same-cycle set and clear of different banks' `full` flags are independent; both take effect.
- A bank cannot be set and cleared in the same cycle, because the write side never targets a full bank.
- Output signals hold stable while `out_valid` && !`out_ready`.
- `in_data` is ignored when `in_valid` is low.

Reset (`reset` low, asynchronous):
- `full`=0, `wr_sel`=`rd_sel`=0, counters=0.
- Hence `in_ready`=1, `out_valid`=0, `out_idx`=0, `out_last`=0, `out_run`=0.
- Bank contents are not reset.
- A partial block is discarded if reset is asserted mid-block; the first accept after release is position 0.

## Timing
- Latency: the first output of a block is valid in the cycle after its 64th input is accepted, when the other bank is empty.
- Sustained throughput: 1 in / 1 out per cycle with both sides unstalled.
- Back-pressure: with `out_ready` held low, exactly 128 coefficients are accepted, then `in_ready` drops in the cycle after the 128th accept.
- `in_ready` rises in the cycle after the last read handshake of the draining bank.
- No combinational path from `in_valid` to `out_valid`, or from `out_ready` to `in_ready`.

## Configuration
Macro: `ZIGZAG_RUNLEN_EN`.

Defined:
- Port `out_run` exists; a 6-bit zero-run register is added.
- `out_run` = count of zero coefficients immediately preceding the current output within the same block, in output order.
- The register updates on each read handshake:
  - if `out_data`==0, it increments;
  - otherwise it clears to 0;
  - in either case it clears to 0 after `out_last`.

Undefined:
- No `out_run` port and no run logic; all other behaviour is identical.

## Test plan
- Forward, ramp: MODE 0, input raster values 0..63 (`out_ready`=1) -> outputs 0,1,8,16,9,2,... ending with 63. `out_idx` runs 0..63 and `out_last` is high only at idx 63. The first output arrives one cycle after the 64th accept.
- Round trip: MODE 0 instance feeding a MODE 1 instance, 4 back-to-back random blocks -> raster output bit-identical to the input. Both sides run 1/cycle with no `in_ready` gaps.
- Back-pressure: `out_ready`=0 with continuous input -> 128 accepts, then `in_ready`=0. Raising `out_ready` for one cycle -> one output. After 64 outputs, `in_ready` returns to 1.
- Reset mid-block: 30 coefficients in, then `reset` pulsed low -> `out_valid`=0, `in_ready`=1. The next 64 inputs form block 0 and output correctly.
- Run length (`ZIGZAG_RUNLEN_EN`, MODE 0): raster[0]=5, raster[63]=7, all others 0. Required outputs:
  - idx 0: data 5, run 0;
  - idx 1: data 0, run 0;
  - idx 62: data 0, run 61;
  - idx 63: data 7, run 62.
  - The next block's idx 0 shows run 0.
- Simultaneous events: block 1's 64th write coincides with block 0's last read -> both `full` updates apply, and block 1 streams out from the next cycle with no bubble.
